// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor controller: sequences one external full-subtractor
// cell LSB-first, carrying the borrow between bits, to form {bout, diff} = a - b - bin.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             fs_a,
  output logic             fs_b,
  output logic             fs_bin,
  input  logic             fs_d,
  input  logic             fs_bout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             brw;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            brw   <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // Cell result enters at the MSB so bit i lands at diff[i] after WIDTH shifts.
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          diff <= {fs_d, diff[WIDTH-1:1]};
          brw  <= fs_bout;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            bout  <= fs_bout;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Cell inputs are forced low outside SHIFT so the cell sees a quiet bus when idle.
  assign fs_a   = (state == SHIFT) & a_sh[0];
  assign fs_b   = (state == SHIFT) & b_sh[0];
  assign fs_bin = (state == SHIFT) & brw;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random bench for serial_subtractor with a behavioural full-subtractor cell.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;
  logic       fs_a;
  logic       fs_b;
  logic       fs_bin;
  logic       fs_d;
  logic       fs_bout;

  int total;
  int bad;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout),
    .fs_a(fs_a), .fs_b(fs_b), .fs_bin(fs_bin), .fs_d(fs_d), .fs_bout(fs_bout)
  );

  // Single-bit full-subtractor cell: d = x - y - z, bout = borrow.
  assign fs_d    = fs_a ^ fs_b ^ fs_bin;
  assign fs_bout = (~fs_a & fs_b) | (~(fs_a ^ fs_b) & fs_bin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents operands on a negedge, holds start across one posedge, then scrambles operands.
  task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic binv);
    @(negedge clk);
    a = av; b = bv; bin = binv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~av; b = ~bv; bin = ~binv;
  endtask

  // From the negedge after the accepting edge, waits for done; lat = edges counted, -1 on timeout.
  task automatic wait_done(output int lat, output int busy_cycles);
    lat = -1;
    busy_cycles = busy ? 1 : 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
      if (busy) busy_cycles++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, diff, bout} !== 11'd0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b done=%b diff=%h bout=%b want all 0", busy, done, diff, bout);
    end
    total++;
    if ({fs_a, fs_b, fs_bin} !== 3'b000) begin
      bad++;
      $display("FAIL reset_fs got %b%b%b want 000", fs_a, fs_b, fs_bin);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat, bc;
    start_op(8'd5, 8'd3, 1'b0);
    wait_done(lat, bc);
    total++;
    if (lat !== 8) begin bad++; $display("FAIL basic_latency got %0d want 8", lat); end
    total++;
    if (bc !== 8) begin bad++; $display("FAIL basic_busy_cycles got %0d want 8", bc); end
    total++;
    if (diff !== 8'h02) begin bad++; $display("FAIL basic_diff got %h want 02", diff); end
    total++;
    if (bout !== 1'b0) begin bad++; $display("FAIL basic_bout got %b want 0", bout); end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got %b want 0", done); end
    repeat (3) @(negedge clk);
    total++;
    if (diff !== 8'h02) begin bad++; $display("FAIL basic_diff_hold got %h want 02", diff); end
  endtask

  task automatic test_vectors;
    logic [7:0] va [4]  = '{8'd3, 8'd0, 8'hFF, 8'h80};
    logic [7:0] vb [4]  = '{8'd5, 8'd0, 8'h00, 8'h7F};
    logic       vc [4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] ed [4]  = '{8'hFE, 8'hFF, 8'hFF, 8'h00};
    logic       eb [4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      start_op(va[i], vb[i], vc[i]);
      wait_done(lat, bc);
      total++;
      if (lat !== 8) begin bad++; $display("FAIL vec%0d_latency got %0d want 8", i, lat); end
      total++;
      if ({bout, diff} !== {eb[i], ed[i]}) begin
        bad++;
        $display("FAIL vec%0d_result got bout=%b diff=%h want bout=%b diff=%h", i, bout, diff, eb[i], ed[i]);
      end
    end
  endtask

  task automatic test_ignore_and_back_to_back;
    int lat, bc;
    start_op(8'd10, 8'd4, 1'b0);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 3) begin a = 8'd1; b = 8'd2; bin = 1'b0; start = 1'b1; end
      if (i == 4) start = 1'b0;
      if (done) begin lat = i; break; end
    end
    total++;
    if (lat !== 8) begin bad++; $display("FAIL ignore_latency got %0d want 8", lat); end
    total++;
    if ({bout, diff} !== 9'h006) begin
      bad++;
      $display("FAIL ignore_result got bout=%b diff=%h want bout=0 diff=06", bout, diff);
    end
    // Still in the done cycle: request the next operation right away.
    a = 8'd9; b = 8'd9; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'd0; b = 8'd1;
    total++;
    if ({busy, done} !== 2'b10) begin
      bad++;
      $display("FAIL b2b_accept got busy=%b done=%b want busy=1 done=0", busy, done);
    end
    wait_done(lat, bc);
    total++;
    if (lat !== 8) begin bad++; $display("FAIL b2b_latency got %0d want 8", lat); end
    total++;
    if ({bout, diff} !== 9'h000) begin
      bad++;
      $display("FAIL b2b_result got bout=%b diff=%h want bout=0 diff=00", bout, diff);
    end
  endtask

  task automatic test_reset_mid;
    int lat, bc;
    int seen;
    start_op(8'd7, 8'd1, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, diff, bout} !== 11'd0) begin
      bad++;
      $display("FAIL midreset_outputs got busy=%b done=%b diff=%h bout=%b want all 0", busy, done, diff, bout);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL midreset_no_done got %0d pulses want 0", seen); end
    start_op(8'd7, 8'd1, 1'b0);
    wait_done(lat, bc);
    total++;
    if (lat !== 8) begin bad++; $display("FAIL midreset_fresh_latency got %0d want 8", lat); end
    total++;
    if ({bout, diff} !== 9'h006) begin
      bad++;
      $display("FAIL midreset_fresh_result got bout=%b diff=%h want bout=0 diff=06", bout, diff);
    end
  endtask

  task automatic test_random;
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] exp;
    int lat, bc;
    for (int n = 0; n < 200; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      exp = {1'b0, ra} - {1'b0, rb} - {8'd0, rc};
      start_op(ra, rb, rc);
      wait_done(lat, bc);
      total++;
      if (lat !== 8) begin bad++; $display("FAIL rand%0d_latency got %0d want 8", n, lat); end
      total++;
      if ({bout, diff} !== exp) begin
        bad++;
        $display("FAIL rand%0d_result a=%h b=%h bin=%b got %h want %h", n, ra, rb, rc, {bout, diff}, exp);
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0) begin bad++; $display("FAIL rand%0d_done_width got %b want 0", n, done); end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_basic();
    test_vectors();
    test_ignore_and_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
